// File: rtl/instruction_fetch_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel
// carrying a 4-byte-aligned byte address, and a response channel returning one
// 32-bit word (or an access error) for every accepted request.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  // Fetch stage side: issues requests, consumes responses.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err
  );

  // Instruction memory side.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one instruction at a time from instruction
// memory, holds it with its PC for decode, follows redirects from execute and
// latches a sticky fault on a misaligned redirect or a memory access error.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_fetch_if.master   imem,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  input  logic                  stall,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [63:0]           if_pc,
  output logic                  if_fault
);

  typedef enum logic [2:0] {
    S_REQ,    // presenting a request at pc
    S_WAIT,   // request accepted, waiting for its response
    S_HOLD,   // instruction presented to decode
    S_DRAIN,  // redirected with a response still owed; discard it
    S_FAULT   // fault latched, fetching stopped until reset
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;

  logic hs;
  logic redir_live;
  logic redir_bad;
  logic redir_good;

  assign hs         = imem.imem_req_valid && imem.imem_req_ready;
  assign redir_live = redirect_valid && (state != S_FAULT);
  assign redir_bad  = redir_live && (redirect_pc[1:0] != 2'b00);
  assign redir_good = redir_live && (redirect_pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= S_REQ;
    else        state <= state_next;
  end

  // Next-state logic; a live redirect overrides normal sequencing.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (redir_bad) begin
      state_next = S_FAULT;
    end else if (redir_good) begin
      case (state)
        S_REQ:   state_next = hs ? S_DRAIN : S_REQ;
        S_WAIT:  state_next = imem.imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_next = S_REQ;
        S_DRAIN: state_next = imem.imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_next = state;
      endcase
    end else begin
      case (state)
        S_REQ:   if (hs) state_next = S_WAIT;
        S_WAIT:  if (imem.imem_rsp_valid)
                   state_next = imem.imem_rsp_err ? S_FAULT : S_HOLD;
        S_HOLD:  if (!stall) state_next = S_REQ;
        S_DRAIN: if (imem.imem_rsp_valid) state_next = S_REQ;
        default: state_next = state;
      endcase
    end
  end

  // Request outputs: only S_REQ requests, and never while reset is asserted.
  always_comb begin
    imem.imem_req_valid = rst_n && (state == S_REQ);
    imem.imem_req_addr  = pc;
  end

  // PC and decode-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= 64'h0;
      if_fault <= 1'b0;
    end else if (redir_bad) begin
      if_fault <= 1'b1;
      if_valid <= 1'b0;
    end else if (redir_good) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else begin
      case (state)
        S_WAIT: begin
          if (imem.imem_rsp_valid && !imem.imem_rsp_err) begin
            if_instr <= imem.imem_rsp_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 64'd4;  // wraps modulo 2^64
          end else if (imem.imem_rsp_valid) begin
            if_fault <= 1'b1;
            if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
          end
        end
        S_FAULT: if_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
